// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_pkg.sv
// Shared definitions for the 9-track AOI22 self-test initiator:
// state encoding, vector width and the reference cell function.
package gf180mcu_fd_sc_mcu9t5v0__bist_pkg;

    localparam int unsigned VEC_W    = 4;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Reference ZN for an AOI22 cell, with {A1,A2,B1,B2} = vec[3:0].
    function automatic logic aoi22_expected(input logic [VEC_W-1:0] vec);
        return ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_vecgen.sv
// Vector counter and per-vector settle counter for the AOI22 self-test.
// load starts a run at vector 0; step advances to the next vector.
module gf180mcu_fd_sc_mcu9t5v0__bist_vecgen
    import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
    parameter int unsigned N_SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [VEC_W-1:0] vec,
    output logic             last_vec,
    output logic             settle_zero
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(N_SETTLE - 1);

    logic [SETTLE_W-1:0] settle_cnt;

    // The settle counter saturates at zero, so it simply holds through SAMPLE and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (load) begin
            vec        <= '0;
            settle_cnt <= SETTLE_INIT;
        end else if (step) begin
            vec        <= vec + 1'b1;
            settle_cnt <= SETTLE_INIT;
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    assign last_vec    = &vec;
    assign settle_zero = (settle_cnt == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi22_bist.sv
// Self-test initiator for the AOI22 cell: sweeps all 16 input vectors,
// checks ZN against the reference and keeps error count and first failing vector.
module gf180mcu_fd_sc_mcu9t5v0__aoi22_bist
    import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
    parameter int unsigned N_SETTLE = 2
) (
    input  logic       CLK,
    input  logic       RN,
    inout  wire        VDD,
    inout  wire        VSS,
    input  logic       START,
    input  logic       ZN,
    output logic       A1,
    output logic       A2,
    output logic       B1,
    output logic       B2,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] ERRCNT,
    output logic [3:0] FAIL_VEC,
    output logic       FAIL_VLD
);

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic             load;
    logic             step;
    logic             last_vec;
    logic             settle_zero;
    logic             mismatch;
    logic             unused_supply;

    assign unused_supply = VDD ^ VSS;

    assign load     = ((state == S_IDLE) || (state == S_DONE)) && START;
    assign step     = (state == S_SAMPLE) && !last_vec;
    assign mismatch = (ZN != aoi22_expected(vec));

    gf180mcu_fd_sc_mcu9t5v0__bist_vecgen #(
        .N_SETTLE(N_SETTLE)
    ) u_vecgen (
        .clk        (CLK),
        .rst_n      (RN),
        .load       (load),
        .step       (step),
        .vec        (vec),
        .last_vec   (last_vec),
        .settle_zero(settle_zero)
    );

    // vec is a register, so the drive pins are glitch-free registered outputs.
    assign {A1, A2, B1, B2} = vec;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= S_IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERRCNT   <= '0;
            FAIL_VEC <= '0;
            FAIL_VLD <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state    <= S_SETTLE;
                        BUSY     <= 1'b1;
                        DONE     <= 1'b0;
                        ERRCNT   <= '0;
                        FAIL_VEC <= '0;
                        FAIL_VLD <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_zero) state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        ERRCNT <= ERRCNT + 5'd1;
                        if (!FAIL_VLD) begin
                            FAIL_VEC <= vec;
                            FAIL_VLD <= 1'b1;
                        end
                    end
                    if (last_vec) begin
                        state <= S_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        state <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign PASS = DONE && (ERRCNT == '0);

endmodule
